// File: rtl/memory_access_pkg.sv
// Shared definitions for the data memory access unit: funct3 access codes,
// FSM state encoding and the lane-select helper.
package memory_access_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } accessStateT;

  // Halfwords snap to an even lane and words to lane 0, so an unaligned
  // address still selects a sensible lane when alignment is not enforced.
  function automatic logic [1:0] laneSelect(input logic [2:0] f3, input logic [1:0] addrLow);
    logic [1:0] lane;
    case (f3[1:0])
      2'd0:    lane = addrLow;
      2'd1:    lane = {addrLow[1], 1'b0};
      default: lane = 2'b00;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/data_memory_access_unit_if.sv
// Data-port bus between the access unit (master) and the memory handler (slave).
interface data_memory_access_unit_if;

  logic        dataMemoryReadEnable;
  logic        dataMemoryWriteEnable;
  logic [31:0] dataMemoryAddress;
  logic [31:0] dataMemoryDataIn;
  logic [31:0] dataMemoryDataOut;

  modport master (
    output dataMemoryReadEnable,
    output dataMemoryWriteEnable,
    output dataMemoryAddress,
    output dataMemoryDataIn,
    input  dataMemoryDataOut
  );

  modport slave (
    input  dataMemoryReadEnable,
    input  dataMemoryWriteEnable,
    input  dataMemoryAddress,
    input  dataMemoryDataIn,
    output dataMemoryDataOut
  );

endinterface

// File: rtl/byte_lane_unit.sv
// Combinational lane arithmetic: store merge into a captured word and
// sign/zero extension of the selected load lane.
module byte_lane_unit
  import memory_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] storeData,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] mergedWord,
  output logic [31:0] extendedLoad
);

  logic [15:0] shifted;
  logic [31:0] laneMask;
  logic [31:0] laneData;

  always_comb begin
    shifted = 16'(word >> {lane, 3'b000});
    extendedLoad = '0;
    case (funct3)
      F3_B:    extendedLoad = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   extendedLoad = {24'd0, shifted[7:0]};
      F3_H:    extendedLoad = {{16{shifted[15]}}, shifted};
      F3_HU:   extendedLoad = {16'd0, shifted};
      F3_W:    extendedLoad = word;
      default: extendedLoad = '0;
    endcase

    // Replicating the operand across all lanes lets one mask place it.
    laneMask = '0;
    laneData = '0;
    case (funct3[1:0])
      2'd0: begin
        laneMask = 32'h0000_00FF << {lane, 3'b000};
        laneData = {4{storeData[7:0]}};
      end
      2'd1: begin
        laneMask = 32'h0000_FFFF << {lane, 3'b000};
        laneData = {2{storeData[15:0]}};
      end
      2'd2: begin
        laneMask = 32'hFFFF_FFFF;
        laneData = storeData;
      end
      default: begin
        laneMask = '0;
        laneData = '0;
      end
    endcase
    mergedWord = (word & ~laneMask) | (laneData & laneMask);
  end

endmodule

// File: rtl/data_memory_access_unit.sv
// Turns MEM-stage load/store requests into word-aligned single-port accesses,
// using read-modify-write for sub-word stores while stalling the pipeline.
module data_memory_access_unit
  import memory_access_pkg::*;
#(
  parameter int CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic        stall,
  output logic        done,
  output logic        fault,
  data_memory_access_unit_if.master dataMem
);

  accessStateT state, nextState;
  logic [31:0] addrReg, storeDataReg, wordReg;
  logic [2:0]  funct3Reg;
  logic        isLoadReg, faultReg;
  logic        request, badFunct3, misaligned, reqFault;
  logic [31:0] mergedWord, extendedLoad;

  assign request    = memRead | memWrite;
  assign badFunct3  = memRead ? ((funct3 == 3'd3) || (funct3[2:1] == 2'b11)) : (funct3 > F3_W);
  assign misaligned = (CHECK_ALIGN != 0) &&
                      (((funct3[1:0] == 2'd1) && address[0]) ||
                       ((funct3[1:0] == 2'd2) && (address[1:0] != 2'b00)));
  assign reqFault   = (memRead & memWrite) | badFunct3 | misaligned;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  // Request fields are frozen on acceptance; the word register holds the read data.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      addrReg      <= '0;
      storeDataReg <= '0;
      funct3Reg    <= '0;
      isLoadReg    <= 1'b0;
      faultReg     <= 1'b0;
      wordReg      <= '0;
    end else begin
      if (state == IDLE && request) begin
        addrReg      <= address;
        storeDataReg <= storeData;
        funct3Reg    <= funct3;
        isLoadReg    <= memRead & ~memWrite;
        faultReg     <= reqFault;
      end
      if (state == READ) wordReg <= dataMem.dataMemoryDataOut;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (request) begin
          if (reqFault)             nextState = DONE;
          else if (memRead)         nextState = READ;
          else if (funct3 == F3_W)  nextState = WRITE;
          else                      nextState = READ;
        end
      end
      READ:    nextState = isLoadReg ? DONE : WRITE;
      WRITE:   nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Reset gating on stall keeps every output low while reset is held.
  always_comb begin
    stall                         = 1'b0;
    done                          = 1'b0;
    fault                         = 1'b0;
    loadData                      = '0;
    dataMem.dataMemoryReadEnable  = 1'b0;
    dataMem.dataMemoryWriteEnable = 1'b0;
    dataMem.dataMemoryAddress     = '0;
    dataMem.dataMemoryDataIn      = '0;
    case (state)
      IDLE: stall = request & resetN;
      READ: begin
        stall                        = 1'b1;
        dataMem.dataMemoryReadEnable = 1'b1;
        dataMem.dataMemoryAddress    = {addrReg[31:2], 2'b00};
      end
      WRITE: begin
        stall                         = 1'b1;
        dataMem.dataMemoryWriteEnable = 1'b1;
        dataMem.dataMemoryAddress     = {addrReg[31:2], 2'b00};
        dataMem.dataMemoryDataIn      = mergedWord;
      end
      DONE: begin
        done     = 1'b1;
        fault    = faultReg;
        loadData = (isLoadReg && !faultReg) ? extendedLoad : '0;
      end
      default: stall = 1'b0;
    endcase
  end

  byte_lane_unit laneUnit (
    .word         (wordReg),
    .storeData    (storeDataReg),
    .funct3       (funct3Reg),
    .lane         (laneSelect(funct3Reg, addrReg[1:0])),
    .mergedWord   (mergedWord),
    .extendedLoad (extendedLoad)
  );

endmodule

// File: tb/tb_data_memory_access_unit.sv
// Self-checking bench: scoreboarded load/store traffic against a word memory
// model, plus alignment-disabled and reset-during-write scenarios.
module tb_data_memory_access_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic        memRead, memWrite;
  logic [2:0]  funct3;
  logic [31:0] address, storeData;
  logic [31:0] loadData;
  logic        stall, done, fault;

  logic        memRead1, memWrite1;
  logic [2:0]  funct31;
  logic [31:0] address1, storeData1;
  logic [31:0] loadData1;
  logic        stall1, done1, fault1;

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];

  int checks = 0;
  int errors = 0;
  logic [31:0] lastReadAddr;

  typedef struct {
    logic [31:0] load;
    logic        flt;
  } sbItemT;
  sbItemT sbQueue[$];

  data_memory_access_unit_if dm0 ();
  data_memory_access_unit_if dm1 ();

  data_memory_access_unit #(.CHECK_ALIGN(1)) dut (
    .clk(clk), .resetN(resetN), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .address(address), .storeData(storeData),
    .loadData(loadData), .stall(stall), .done(done), .fault(fault),
    .dataMem(dm0)
  );

  data_memory_access_unit #(.CHECK_ALIGN(0)) dutNoAlign (
    .clk(clk), .resetN(resetN), .memRead(memRead1), .memWrite(memWrite1),
    .funct3(funct31), .address(address1), .storeData(storeData1),
    .loadData(loadData1), .stall(stall1), .done(done1), .fault(fault1),
    .dataMem(dm1)
  );

  always #5 clk = ~clk;

  // Word memories: combinational read while enabled, write on the clock edge.
  assign dm0.dataMemoryDataOut = dm0.dataMemoryReadEnable ? mem0[dm0.dataMemoryAddress[9:2]] : 32'd0;
  assign dm1.dataMemoryDataOut = dm1.dataMemoryReadEnable ? mem1[dm1.dataMemoryAddress[9:2]] : 32'd0;

  always @(posedge clk) begin
    if (dm0.dataMemoryWriteEnable) mem0[dm0.dataMemoryAddress[9:2]] <= dm0.dataMemoryDataIn;
    if (dm1.dataMemoryWriteEnable) mem1[dm1.dataMemoryAddress[9:2]] <= dm1.dataMemoryDataIn;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Scoreboard consumer: every done pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sbUnexpectedDone", 32'd1, 32'd0);
      end else begin
        sbItemT item;
        item = sbQueue.pop_front();
        checkOutput("sbLoadData", loadData, item.load);
        checkOutput("sbFault", {31'd0, fault}, {31'd0, item.flt});
      end
    end
  end

  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] sd, input logic [31:0] expLoad,
                               input logic expFault, input int expLat,
                               input int expReads, input int expWrites);
    int cycles, reads, writes, stalls, viol;
    logic seen;
    sbQueue.push_back('{load: expLoad, flt: expFault});
    @(posedge clk); #1;
    memRead = rd; memWrite = wr; funct3 = f3; address = addr; storeData = sd;
    cycles = 0; reads = 0; writes = 0; stalls = 0; viol = 0; seen = 1'b0;
    while (!seen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (dm0.dataMemoryReadEnable) begin
        reads++;
        lastReadAddr = dm0.dataMemoryAddress;
      end
      if (dm0.dataMemoryWriteEnable) writes++;
      if (stall) stalls++;
      if (dm0.dataMemoryReadEnable && dm0.dataMemoryWriteEnable) viol++;
      if (!dm0.dataMemoryReadEnable && !dm0.dataMemoryWriteEnable && dm0.dataMemoryAddress != 0) viol++;
      if (!dm0.dataMemoryWriteEnable && dm0.dataMemoryDataIn != 0) viol++;
      if (done) seen = 1'b1;
      else if (cycles >= 2) begin
        address = ~addr;
        storeData = ~sd;
      end
    end
    #1;
    memRead = 1'b0; memWrite = 1'b0; address = '0; storeData = '0; funct3 = '0;
    checkOutput({tag, "Timeout"}, {31'd0, seen}, 32'd1);
    checkOutput({tag, "Latency"}, cycles, expLat);
    checkOutput({tag, "Reads"}, reads, expReads);
    checkOutput({tag, "Writes"}, writes, expWrites);
    checkOutput({tag, "Stalls"}, stalls, expLat - 1);
    checkOutput({tag, "BusRules"}, viol, 0);
  endtask

  task automatic runNoAlign(input logic rd, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sd, output logic [31:0] ld,
                            output logic flt, output int lat);
    @(posedge clk); #1;
    memRead1 = rd; memWrite1 = ~rd; funct31 = f3; address1 = addr; storeData1 = sd;
    lat = 0; ld = '0; flt = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done1) begin
        ld = loadData1;
        flt = fault1;
        break;
      end
    end
    #1;
    memRead1 = 1'b0; memWrite1 = 1'b0;
  endtask

  initial begin
    logic [31:0] ld;
    logic flt;
    int lat;
    int waitCycles;

    resetN = 1'b0;
    memRead = 0; memWrite = 0; funct3 = 0; address = 0; storeData = 0;
    memRead1 = 0; memWrite1 = 0; funct31 = 0; address1 = 0; storeData1 = 0;
    lastReadAddr = '0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    #12;
    checkOutput("resetCtrl", {27'd0, stall, done, fault, dm0.dataMemoryReadEnable, dm0.dataMemoryWriteEnable}, 32'd0);
    checkOutput("resetLoad", loadData, 32'd0);
    @(negedge clk); resetN = 1'b1;

    mem0[8'h40] = 32'h1122_3344;
    applyStimulus("lw", 1, 0, 3'd2, 32'h100, 32'h0, 32'h1122_3344, 0, 3, 1, 0);
    checkOutput("lwReadAddr", lastReadAddr, 32'h100);

    mem0[8'h40] = 32'h80FF_7F01;
    applyStimulus("lb",  1, 0, 3'd0, 32'h103, 32'h0, 32'hFFFF_FF80, 0, 3, 1, 0);
    applyStimulus("lbu", 1, 0, 3'd4, 32'h103, 32'h0, 32'h0000_0080, 0, 3, 1, 0);
    applyStimulus("lh",  1, 0, 3'd1, 32'h102, 32'h0, 32'hFFFF_80FF, 0, 3, 1, 0);
    applyStimulus("lhu", 1, 0, 3'd5, 32'h100, 32'h0, 32'h0000_7F01, 0, 3, 1, 0);
    applyStimulus("lbPos", 1, 0, 3'd0, 32'h101, 32'h0, 32'h0000_007F, 0, 3, 1, 0);

    mem0[8'h40] = 32'h1122_3344;
    applyStimulus("sb", 0, 1, 3'd0, 32'h101, 32'h5555_55AB, 32'h0, 0, 4, 1, 1);
    checkOutput("sbMem", mem0[8'h40], 32'h1122_AB44);
    applyStimulus("sh", 0, 1, 3'd1, 32'h102, 32'h1234_BEEF, 32'h0, 0, 4, 1, 1);
    checkOutput("shMem", mem0[8'h40], 32'hBEEF_AB44);
    applyStimulus("sw", 0, 1, 3'd2, 32'h104, 32'hDEAD_BEEF, 32'h0, 0, 3, 0, 1);
    checkOutput("swMem", mem0[8'h41], 32'hDEAD_BEEF);

    applyStimulus("swMisaligned", 0, 1, 3'd2, 32'h106, 32'h0BAD_0BAD, 32'h0, 1, 2, 0, 0);
    checkOutput("swMisalignedMem", mem0[8'h41], 32'hDEAD_BEEF);
    applyStimulus("lhMisaligned", 1, 0, 3'd1, 32'h101, 32'h0, 32'h0, 1, 2, 0, 0);
    applyStimulus("loadIllegal", 1, 0, 3'd6, 32'h100, 32'h0, 32'h0, 1, 2, 0, 0);
    applyStimulus("storeIllegal", 0, 1, 3'd4, 32'h100, 32'h0, 32'h0, 1, 2, 0, 0);
    checkOutput("storeIllegalMem", mem0[8'h40], 32'hBEEF_AB44);

    // Reset during the write phase of a halfword store must leave memory untouched.
    mem0[8'h80] = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    memWrite = 1'b1; funct3 = 3'd1; address = 32'h200; storeData = 32'h0000_1234;
    waitCycles = 0;
    do begin
      @(negedge clk);
      waitCycles++;
    end while (!dm0.dataMemoryWriteEnable && waitCycles < 10);
    checkOutput("rstReachedWrite", waitCycles, 3);
    resetN = 1'b0;
    #1;
    checkOutput("rstWriteDrop", {31'd0, dm0.dataMemoryWriteEnable}, 32'd0);
    checkOutput("rstOutputs", {27'd0, stall, done, fault, dm0.dataMemoryReadEnable, dm0.dataMemoryWriteEnable}, 32'd0);
    checkOutput("rstBusAddr", dm0.dataMemoryAddress | dm0.dataMemoryDataIn | loadData, 32'd0);
    memWrite = 1'b0; funct3 = 0; address = 0; storeData = 0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rstMemKept", mem0[8'h80], 32'hA5A5_A5A5);
    @(negedge clk); resetN = 1'b1;
    @(negedge clk);
    checkOutput("postRstOutputs", {27'd0, stall, done, fault, dm0.dataMemoryReadEnable, dm0.dataMemoryWriteEnable}, 32'd0);

    applyStimulus("bothReq", 1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 1, 2, 0, 0);
    mem0[8'h00] = 32'hFEDC_0000;
    applyStimulus("lhuAfter", 1, 0, 3'd5, 32'h002, 32'h0, 32'h0000_FEDC, 0, 3, 1, 0);

    // Alignment disabled: address low bits are ignored rather than faulting.
    mem1[8'h40] = 32'h80FF_7F01;
    runNoAlign(1'b0, 3'd2, 32'h106, 32'hCAFE_BABE, ld, flt, lat);
    checkOutput("naSwFault", {31'd0, flt}, 32'd0);
    checkOutput("naSwLatency", lat, 3);
    checkOutput("naSwMem", mem1[8'h41], 32'hCAFE_BABE);
    runNoAlign(1'b1, 3'd1, 32'h103, 32'h0, ld, flt, lat);
    checkOutput("naLhLoad", ld, 32'hFFFF_80FF);
    checkOutput("naLhFault", {31'd0, flt}, 32'd0);
    runNoAlign(1'b1, 3'd2, 32'h107, 32'h0, ld, flt, lat);
    checkOutput("naLwLoad", ld, 32'hCAFE_BABE);

    repeat (2) @(posedge clk);
    checkOutput("sbEmpty", sbQueue.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_access_unit.md
Name: data_memory_access_unit

Overview:
- Sits directly upstream of the memory handler's data port, between the pipeline MEM stage and the shared single-port memory.
- Converts RISC-V load/store requests (byte, halfword, word; signed or unsigned) into word-aligned single-port accesses.
- Sub-word stores use read-modify-write; the pipeline is stalled for the duration.
- Keeps both data enables low whenever idle, so the handler serves instruction fetch in those cycles.

Parameters:
- CHECK_ALIGN, default 1. If 1, misaligned half/word accesses raise a fault and are not issued. If 0, address bits below the access size are ignored and the access is forced aligned.

Ports:
- clk  in  1  system clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- memRead  in  1  load request from MEM stage, held while stall=1
- memWrite  in  1  store request from MEM stage, held while stall=1
- funct3  in  3  access type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU (loads); 0 SB, 1 SH, 2 SW (stores)
- address  in  32  byte address
- storeData  in  32  store operand; the low byte/half is used for SB/SH
- loadData  out  32  extended load result, valid when done=1
- stall  out  1  pipeline hold
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle pulse on misaligned/illegal access, coincident with done
- dataMemoryReadEnable  out  1  to memory handler
- dataMemoryWriteEnable  out  1  to memory handler
- dataMemoryAddress  out  32  word address, {addr[31:2],2'b00}
- dataMemoryDataIn  out  32  write word
- dataMemoryDataOut  in  32  read word; valid combinationally in a cycle with read enable asserted

Behaviour:
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If memRead^memWrite: latch address, funct3 and storeData; stall=1.
  - Then go to READ for loads, SB and SH; WRITE for SW; DONE with fault set if misaligned or funct3 is illegal.
  - Misaligned means: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: loads 3/6/7, stores 3..7.
  - memRead&memWrite together: DONE with fault, no memory access.
- READ: dataMemoryReadEnable=1, address from the latched request. Capture dataMemoryDataOut into the word register at the clock edge. Next state is DONE for loads, WRITE for SB/SH.
- WRITE:
  - dataMemoryWriteEnable=1; the write commits at the clock edge.
  - SW writes storeData.
  - SB/SH merge the captured word with the low byte/half in lane addr[1:0], little-endian. Untouched bytes keep their old values.
  - Next state is DONE.
- DONE:
  - stall=0, done=1, fault as latched. Next state is IDLE.
  - loadData = selected lane of the captured word: sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW. loadData is 0 for stores and faults.
- stall=1 in IDLE only when a request is present; in READ and WRITE it is always 1.
- Latency (request seen → done): load 3 cycles, SW 3 cycles, SB/SH 4 cycles, fault 2 cycles.
- The request is latched, so changes on the request inputs after acceptance are ignored. The next request is evaluated in the IDLE cycle after DONE.
- Both enables are 0 in IDLE and DONE; instruction fetch proceeds in those cycles.
- At most one enable is high in any cycle.
- dataMemoryAddress and dataMemoryDataIn are 0 whenever their enables are low.
- Reset (async, any state): go to IDLE immediately. Clear latched request and word register. All outputs are 0. An in-flight WRITE is dropped because the enable falls at once, so memory is unchanged.
- With CHECK_ALIGN=0 no fault is raised for alignment. Lane select uses {addr[1],1'b0} for halfwords and 0 for words.

Decomposition:
- Shared package memory_access_pkg holds:
  - funct3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5
  - the state encoding: IDLE=0, READ=1, WRITE=2, DONE=3
- One combinational sub-module, byte_lane_unit, contains all lane arithmetic:
  - inputs: word, storeData, funct3, addr[1:0]
  - outputs: mergedWord, extendedLoad
- The top level holds the FSM and the latches.

Test Plan:
- LW at 0x100, memory word 0x11223344 → READ enable for one cycle with address 0x100; done on cycle 3; loadData=0x11223344; fault=0.
- LB at 0x103, word 0x80FF7F01 → loadData=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SB at 0x101, storeData=0xAB, old word 0x11223344 → one READ then one WRITE of 0x1122AB44. stall=1 for 3 cycles, then done. Instruction fetch is unaffected in IDLE/DONE.
- SW at 0x106 with CHECK_ALIGN=1 → no enable ever asserted; done and fault pulse on cycle 2; memory unchanged. With CHECK_ALIGN=0 → word written at 0x104.
- Assert resetN=0 during the WRITE state of SH at 0x200 → write enable drops immediately; the word at 0x200 is unchanged. After release: all outputs 0, state IDLE.
- memRead=memWrite=1 → fault pulse, no access. Then LHU at 0x002 with word 0xFEDC0000 on the following request → loadData=0x0000FEDC.
